// File: rtl/vend_pkg.sv
// Shared constants and types for the vending control stage: coin codes and
// their cent values, error codes, external state encodings, and the FSM enum.
package vend_pkg;

    localparam int IDX_W = 4;

    localparam logic [1:0] COIN_5   = 2'b00;
    localparam logic [1:0] COIN_10  = 2'b01;
    localparam logic [1:0] COIN_25  = 2'b10;
    localparam logic [1:0] COIN_100 = 2'b11;

    localparam logic [7:0] CENTS_5   = 8'd5;
    localparam logic [7:0] CENTS_10  = 8'd10;
    localparam logic [7:0] CENTS_25  = 8'd25;
    localparam logic [7:0] CENTS_100 = 8'd100;

    localparam logic [1:0] ERR_TIMEOUT   = 2'd0;
    localparam logic [1:0] ERR_FUNDS     = 2'd1;
    localparam logic [1:0] ERR_SOLD_OUT  = 2'd2;
    localparam logic [1:0] ERR_BAD_INDEX = 2'd3;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_COLLECT = 2'b01;
    localparam logic [1:0] ST_VEND    = 2'b10;
    localparam logic [1:0] ST_RETURN  = 2'b11;

    typedef enum logic [2:0] {
        FSM_IDLE,
        FSM_COLLECT,
        FSM_CHECK,
        FSM_REQ,
        FSM_REL,
        FSM_RETURN
    } fsm_t;

    // Cent value of a coin code.
    function automatic logic [7:0] coin_cents(input logic [1:0] code);
        case (code)
            COIN_5:  return CENTS_5;
            COIN_10: return CENTS_10;
            COIN_25: return CENTS_25;
            default: return CENTS_100;
        endcase
    endfunction

endpackage

// File: rtl/vend_credit_accum.sv
// Credit register: decodes coins, enforces the credit ceiling, flags refused
// coins, and clears when change has been returned.
module vend_credit_accum
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    input  logic                accept_en,
    input  logic                drop_en,
    input  logic                clear,
    output logic [CREDIT_W-1:0] credit,
    output logic                coin_reject,
    output logic                coin_accepted
);

    logic [CREDIT_W-1:0] credit_reg;
    logic                coin_reject_reg;
    logic [CREDIT_W:0]   sum;
    logic                fits;

    // Candidate credit and ceiling test; a coin swallowed by a cancel is neither added nor refused.
    always_comb begin
        sum           = {1'b0, credit_reg} + (CREDIT_W+1)'(coin_cents(coin_code));
        fits          = (sum <= (CREDIT_W+1)'(MAX_CREDIT));
        coin_accepted = coin_valid && accept_en && !drop_en && fits;
    end

    // Credit register and one-cycle reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            credit_reg      <= '0;
            coin_reject_reg <= 1'b0;
        end else begin
            coin_reject_reg <= coin_valid && !drop_en && !(accept_en && fits);
            if (clear) begin
                credit_reg <= '0;
            end else if (coin_accepted) begin
                credit_reg <= sum[CREDIT_W-1:0];
            end
        end
    end

    assign credit      = credit_reg;
    assign coin_reject = coin_reject_reg;

endmodule

// File: rtl/vend_controller.sv
// Vending control stage: collects credit, checks a selection against price and
// stock, runs the four-phase decrement handshake with the inventory monitor,
// and returns change.
module vend_controller
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS   = 8,
    parameter int PRICE_W     = 8,
    parameter int CREDIT_W    = 8,
    parameter int MAX_CREDIT  = 200,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         coin_valid,
    input  logic [1:0]                   coin_code,
    input  logic                         select_valid,
    input  logic [IDX_W-1:0]             select_index,
    input  logic                         cancel,
    input  logic [NUM_SLOTS*PRICE_W-1:0] price_table,
    input  logic                         in_stock,
    input  logic                         reduce_inventory_done,
    output logic                         reduce_inventory,
    output logic [IDX_W-1:0]             cur_index,
    output logic [1:0]                   state,
    output logic [CREDIT_W-1:0]          credit,
    output logic                         coin_reject,
    output logic                         vend_done,
    output logic                         change_valid,
    output logic [CREDIT_W-1:0]          change_amount,
    output logic                         err_valid,
    output logic [1:0]                   err_code
);

    localparam int AMT_W  = (CREDIT_W > PRICE_W) ? CREDIT_W : PRICE_W;
    localparam int CNT_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    fsm_t                fsm_reg, fsm_next;
    logic                check_phase_reg;
    logic [CNT_W-1:0]    timer_reg;
    logic [IDX_W-1:0]    cur_index_reg;
    logic [PRICE_W-1:0]  price_reg;
    logic [CREDIT_W-1:0] change_reg;
    logic                err_valid_reg;
    logic [1:0]          err_code_reg;
    logic                vend_done_reg;

    logic [PRICE_W-1:0]  price_arr [NUM_SLOTS];
    logic [PRICE_W-1:0]  sel_price;
    logic [CREDIT_W-1:0] credit_val;
    logic coin_accepted, coin_open, cancel_go, select_go;
    logic index_bad, funds_low, check_fail, decide, timeout_hit, req_timeout, rel_exit;
    logic [1:0] fail_code;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_price
            assign price_arr[gi] = price_table[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    vend_credit_accum #(
        .CREDIT_W   (CREDIT_W),
        .MAX_CREDIT (MAX_CREDIT)
    ) u_credit (
        .clk           (clk),
        .rst           (rst),
        .coin_valid    (coin_valid),
        .coin_code     (coin_code),
        .accept_en     (coin_open),
        .drop_en       (cancel_go),
        .clear         (fsm_reg == FSM_RETURN),
        .credit        (credit_val),
        .coin_reject   (coin_reject),
        .coin_accepted (coin_accepted)
    );

    // Request qualification, price lookup and the prioritised CHECK verdict.
    always_comb begin
        coin_open   = (fsm_reg == FSM_IDLE) || (fsm_reg == FSM_COLLECT);
        cancel_go   = cancel && coin_open && (credit_val != '0);
        select_go   = select_valid && !coin_valid && !cancel_go && (fsm_reg == FSM_COLLECT);
        index_bad   = ({1'b0, cur_index_reg} >= (IDX_W+1)'(NUM_SLOTS));
        sel_price   = index_bad ? '0 : price_arr[cur_index_reg[SLOT_W-1:0]];
        funds_low   = AMT_W'(credit_val) < AMT_W'(sel_price);
        check_fail  = index_bad || funds_low || !in_stock;
        if (index_bad)      fail_code = ERR_BAD_INDEX;
        else if (funds_low) fail_code = ERR_FUNDS;
        else                fail_code = ERR_SOLD_OUT;
        decide      = (fsm_reg == FSM_CHECK) && check_phase_reg;
        timeout_hit = (timer_reg == CNT_W'(TIMEOUT_CYC - 1));
        req_timeout = (fsm_reg == FSM_REQ) && !reduce_inventory_done && timeout_hit;
        rel_exit    = (fsm_reg == FSM_REL) && !reduce_inventory_done;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) fsm_reg <= FSM_IDLE;
        else     fsm_reg <= fsm_next;
    end

    // FSM next-state logic.
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            FSM_IDLE: begin
                if (cancel_go)          fsm_next = FSM_RETURN;
                else if (coin_accepted) fsm_next = FSM_COLLECT;
            end
            FSM_COLLECT: begin
                if (cancel_go)      fsm_next = FSM_RETURN;
                else if (select_go) fsm_next = FSM_CHECK;
            end
            FSM_CHECK: begin
                if (decide) fsm_next = check_fail ? FSM_COLLECT : FSM_REQ;
            end
            FSM_REQ: begin
                if (reduce_inventory_done) fsm_next = FSM_REL;
                else if (timeout_hit)      fsm_next = FSM_RETURN;
            end
            FSM_REL: begin
                if (!reduce_inventory_done) fsm_next = FSM_RETURN;
            end
            FSM_RETURN: fsm_next = FSM_IDLE;
            default:    fsm_next = FSM_IDLE;
        endcase
    end

    // Datapath: CHECK phase, REQ timer, latched index/price/change and event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            check_phase_reg <= 1'b0;
            timer_reg       <= '0;
            cur_index_reg   <= '0;
            price_reg       <= '0;
            change_reg      <= '0;
            err_valid_reg   <= 1'b0;
            err_code_reg    <= '0;
            vend_done_reg   <= 1'b0;
        end else begin
            check_phase_reg <= (fsm_reg == FSM_CHECK) && !check_phase_reg;
            timer_reg       <= (fsm_reg == FSM_REQ) ? timer_reg + CNT_W'(1) : '0;
            if (select_go) cur_index_reg <= select_index;
            if (decide)    price_reg     <= sel_price;
            if (cancel_go || req_timeout) begin
                change_reg <= credit_val;
            end else if (rel_exit) begin
                change_reg <= CREDIT_W'(AMT_W'(credit_val) - AMT_W'(price_reg));
            end
            err_valid_reg <= (decide && check_fail) || req_timeout;
            err_code_reg  <= (decide && check_fail) ? fail_code : ERR_TIMEOUT;
            vend_done_reg <= rel_exit;
        end
    end

    // Outputs decoded from the FSM and datapath registers.
    always_comb begin
        case (fsm_reg)
            FSM_IDLE:    state = ST_IDLE;
            FSM_COLLECT: state = ST_COLLECT;
            FSM_RETURN:  state = ST_RETURN;
            default:     state = ST_VEND;
        endcase
        reduce_inventory = (fsm_reg == FSM_REQ);
        change_valid     = (fsm_reg == FSM_RETURN) && (change_reg != '0);
        change_amount    = (fsm_reg == FSM_RETURN) ? change_reg : '0;
        cur_index        = cur_index_reg;
        credit           = credit_val;
        err_valid        = err_valid_reg;
        err_code         = err_code_reg;
        vend_done        = vend_done_reg;
    end

endmodule
